// File: rtl/mtrx_pkg.sv
// rtl/mtrx_pkg.sv - shared widths and FSM state encodings for the matrix write scheduler
package mtrx_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 12;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_RUN  = 1'b1
    } fill_state_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_WAIT  = 2'd2
    } swap_state_t;

endpackage

// File: rtl/mtrx_fill_gen.sv
// rtl/mtrx_fill_gen.sv - block-fill address/remaining counters with wrap or stop at the top address
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        qualified fill request (caller has already gated on swap state)
//   base, len    first address and word count (len==0 is ignored here)
//   colour_in    fill colour, latched on accept
//   advance      this cycle's fill word is granted the write port
//   busy         fill engine in F_RUN
//   addr, colour address and colour of the word offered this cycle
//
// Build option: MTRX_SCHED_WRAP_EN makes addresses wrap modulo 2^ADDR_W;
// otherwise the fill ends after the top address is written.
module mtrx_fill_gen
    import mtrx_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] colour_in,
    input  logic              advance,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] colour
);

    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ONE_R = {{ADDR_W{1'b0}}, 1'b1};

    fill_state_t       state, state_next;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W:0]   rem, rem_next;
    logic [DATA_W-1:0] colour_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= F_IDLE;
            addr   <= '0;
            rem    <= '0;
            colour <= '0;
        end else begin
            state  <= state_next;
            addr   <= addr_next;
            rem    <= rem_next;
            colour <= colour_next;
        end
    end

    always_comb begin
        state_next  = state;
        addr_next   = addr;
        rem_next    = rem;
        colour_next = colour;
        case (state)
            F_IDLE: begin
                if (start && (len != '0)) begin
                    state_next  = F_RUN;
                    addr_next   = base;
                    rem_next    = len;
                    colour_next = colour_in;
                end
            end
            F_RUN: begin
                if (advance) begin
                    addr_next = addr + ONE_A;
                    rem_next  = rem - ONE_R;
                    if (rem == ONE_R) begin
                        state_next = F_IDLE;
                    end
`ifndef MTRX_SCHED_WRAP_EN
                    // Top address written: drop whatever is left.
                    if (addr == '1) begin
                        state_next = F_IDLE;
                    end
`endif
                end
            end
            default: state_next = F_IDLE;
        endcase
    end

    assign busy = (state == F_RUN);

endmodule

// File: rtl/mtrx_wr_sched.sv
// rtl/mtrx_wr_sched.sv - matrix write-port arbiter (host over fill) and front/back buffer swap sequencer
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   host_wr, host_addr, host_data       host single-word write
//   fill_start, fill_base, fill_len,
//   fill_data                           block-fill request
//   swap_req, buf_current               swap request and displayed buffer
//   mtrx_wr, mtrx_wr_addr, mtrx_wr_data registered matrix write port
//   buf_select                          requested display buffer
//   fill_busy, swap_busy                engine status
//   swap_done                           one-cycle pulse on confirmed swap
//   swap_err                            sticky swap timeout flag
//
// Build option: MTRX_SCHED_WRAP_EN (fill address wrap, see mtrx_fill_gen).
module mtrx_wr_sched
    import mtrx_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int SWAP_TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              swap_req,
    input  logic              buf_current,
    output logic              mtrx_wr,
    output logic [ADDR_W-1:0] mtrx_wr_addr,
    output logic [DATA_W-1:0] mtrx_wr_data,
    output logic              buf_select,
    output logic              fill_busy,
    output logic              swap_busy,
    output logic              swap_done,
    output logic              swap_err
);

    localparam int                CNT_W    = (SWAP_TIMEOUT > 1) ? $clog2(SWAP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SWAP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic              fill_run;
    logic              fill_adv;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_colour;

    swap_state_t       swap_state, swap_next;
    logic [CNT_W-1:0]  to_cnt;
    logic              sel_toggle, done_set, err_set, err_clr, cnt_clr;

    // Host always wins; the fill simply does not advance on a host cycle.
    assign fill_adv = fill_run && !host_wr;

    mtrx_fill_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (fill_start && !swap_busy),
        .base      (fill_base),
        .len       (fill_len),
        .colour_in (fill_data),
        .advance   (fill_adv),
        .busy      (fill_run),
        .addr      (fill_addr),
        .colour    (fill_colour)
    );

    assign fill_busy = fill_run;

    always_comb begin
        swap_next  = swap_state;
        sel_toggle = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        cnt_clr    = 1'b0;
        case (swap_state)
            S_IDLE: begin
                if (swap_req) begin
                    swap_next = S_DRAIN;
                    err_clr   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!fill_run) begin
                    swap_next  = S_WAIT;
                    sel_toggle = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end
            S_WAIT: begin
                // A confirmation on the final timeout cycle still counts as success.
                if (buf_current == buf_select) begin
                    swap_next = S_IDLE;
                    done_set  = 1'b1;
                end else if (to_cnt == CNT_LAST) begin
                    swap_next = S_IDLE;
                    err_set   = 1'b1;
                end
            end
            default: swap_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            swap_state   <= S_IDLE;
            to_cnt       <= '0;
            mtrx_wr      <= 1'b0;
            mtrx_wr_addr <= '0;
            mtrx_wr_data <= '0;
            buf_select   <= 1'b0;
            swap_busy    <= 1'b0;
            swap_done    <= 1'b0;
            swap_err     <= 1'b0;
        end else begin
            swap_state <= swap_next;
            swap_busy  <= (swap_next != S_IDLE);
            swap_done  <= done_set;
            mtrx_wr    <= host_wr || fill_adv;
            if (host_wr) begin
                mtrx_wr_addr <= host_addr;
                mtrx_wr_data <= host_data;
            end else if (fill_adv) begin
                mtrx_wr_addr <= fill_addr;
                mtrx_wr_data <= fill_colour;
            end
            if (sel_toggle) begin
                buf_select <= ~buf_select;
            end
            if (err_clr) begin
                swap_err <= 1'b0;
            end else if (err_set) begin
                swap_err <= 1'b1;
            end
            if (cnt_clr) begin
                to_cnt <= '0;
            end else if (swap_state == S_WAIT) begin
                to_cnt <= to_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mtrx_wr_sched.sv
// tb/tb_mtrx_wr_sched.sv - self-checking bench for mtrx_wr_sched with a behavioural reference model
module tb_mtrx_wr_sched;

    localparam int AW  = 14;
    localparam int DW  = 12;
    localparam int TO  = 16;
    localparam int TOP = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, host_wr, fill_start, swap_req, buf_current;
    logic [AW-1:0] host_addr, fill_base;
    logic [AW:0]   fill_len;
    logic [DW-1:0] host_data, fill_data;
    logic          mtrx_wr, buf_select, fill_busy, swap_busy, swap_done, swap_err;
    logic [AW-1:0] mtrx_wr_addr;
    logic [DW-1:0] mtrx_wr_data;

    mtrx_wr_sched #(.ADDR_W(AW), .DATA_W(DW), .SWAP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_wr(host_wr), .host_addr(host_addr), .host_data(host_data),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_data(fill_data),
        .swap_req(swap_req), .buf_current(buf_current),
        .mtrx_wr(mtrx_wr), .mtrx_wr_addr(mtrx_wr_addr), .mtrx_wr_data(mtrx_wr_data),
        .buf_select(buf_select), .fill_busy(fill_busy), .swap_busy(swap_busy),
        .swap_done(swap_done), .swap_err(swap_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: expected outputs plus abstract fill/swap progress.
    bit m_wr, m_sel, m_fbusy, m_sbusy, m_done, m_err;
    int m_addr, m_data;
    bit f_on;
    int f_addr, f_left, f_col;
    int s_phase;   // 0 idle, 1 waiting for fill to finish, 2 waiting for display
    int s_cnt;

    // Observation log of DUT writes.
    int wa_q[$];
    int wd_q[$];
    int wb_q[$];
    int done_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit o_on, o_sb, o_sel, grant;
        int o_addr, o_ph;
        o_on = f_on; o_addr = f_addr; o_sb = m_sbusy; o_sel = m_sel; o_ph = s_phase;
        if (!rst_n) begin
            m_wr = 0; m_addr = 0; m_data = 0; m_sel = 0; m_fbusy = 0; m_sbusy = 0;
            m_done = 0; m_err = 0; f_on = 0; s_phase = 0; s_cnt = 0;
            return;
        end
        grant = o_on && !host_wr;
        m_wr  = host_wr || grant;
        if (host_wr) begin
            m_addr = int'(host_addr); m_data = int'(host_data);
        end else if (grant) begin
            m_addr = o_addr; m_data = f_col;
        end
        if (grant) begin
            f_left--;
`ifdef MTRX_SCHED_WRAP_EN
            f_on = (f_left != 0);
`else
            f_on = (f_left != 0) && (o_addr != TOP);
`endif
            f_addr = (o_addr + 1) % (TOP + 1);
        end
        if (!o_on && fill_start && fill_len != 0 && !o_sb) begin
            f_on = 1; f_addr = int'(fill_base); f_left = int'(fill_len); f_col = int'(fill_data);
        end
        m_done = 0;
        case (o_ph)
            0: if (swap_req) begin s_phase = 1; m_err = 0; end
            1: if (!o_on) begin s_phase = 2; m_sel = !o_sel; s_cnt = 0; end
            default: begin
                if (buf_current == o_sel) begin s_phase = 0; m_done = 1; end
                else if (s_cnt == TO - 1) begin s_phase = 0; m_err = 1; end
                else s_cnt++;
            end
        endcase
        m_fbusy = f_on;
        m_sbusy = (s_phase != 0);
    endtask

    task automatic compare_all();
        chk("mtrx_wr", 32'(mtrx_wr), 32'(m_wr));
        if (m_wr) begin
            chk("mtrx_wr_addr", 32'(mtrx_wr_addr), m_addr);
            chk("mtrx_wr_data", 32'(mtrx_wr_data), m_data);
        end
        chk("buf_select", 32'(buf_select), 32'(m_sel));
        chk("fill_busy", 32'(fill_busy), 32'(m_fbusy));
        chk("swap_busy", 32'(swap_busy), 32'(m_sbusy));
        chk("swap_done", 32'(swap_done), 32'(m_done));
        chk("swap_err", 32'(swap_err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        cyc++;
        if (mtrx_wr === 1'b1) begin
            wa_q.push_back(int'(mtrx_wr_addr));
            wd_q.push_back(int'(mtrx_wr_data));
            wb_q.push_back(int'(fill_busy));
        end
        if (swap_done === 1'b1) done_cnt++;
    endtask

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wb_q.delete(); done_cnt = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_fill(input int base, input int len, input int col);
        fill_base = AW'(base); fill_len = (AW+1)'(len); fill_data = DW'(col);
        fill_start = 1; tick(); fill_start = 0;
    endtask

    initial begin
        int exp_a[$];
        int last_busy, tog;
        rst_n = 0; host_wr = 0; host_addr = '0; host_data = '0; fill_start = 0;
        fill_base = '0; fill_len = '0; fill_data = '0; swap_req = 0; buf_current = 0;
        idle(3);
        chk("reset_mtrx_wr", 32'(mtrx_wr), 0);
        chk("reset_addr", 32'(mtrx_wr_addr), 0);
        chk("reset_flags", {26'd0, buf_select, fill_busy, swap_busy, swap_done, swap_err, mtrx_wr}, 0);
        rst_n = 1;
        idle(2);

        // Single host write.
        clear_log();
        host_wr = 1; host_addr = 14'h0005; host_data = 12'hF00; tick(); host_wr = 0;
        chk("host_wr_latency", 32'(mtrx_wr), 1);
        idle(3);
        chk("host_count", wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            chk("host_addr", wa_q[0], 32'h0005);
            chk("host_data", wd_q[0], 32'hF00);
        end

        // Plain 4-word fill.
        clear_log();
        start_fill(16'h2000, 4, 12'h0A5);
        chk("fill_busy_rise", 32'(fill_busy), 1);
        chk("fill_first_not_yet", 32'(mtrx_wr), 0);
        idle(6);
        exp_a = '{32'h2000, 32'h2001, 32'h2002, 32'h2003};
        chk("fill4_count", wa_q.size(), 4);
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            chk("fill4_addr", wa_q[i], exp_a[i]);
            chk("fill4_data", wd_q[i], 32'h0A5);
        end
        if (wb_q.size() == 4) begin
            chk("fill4_busy_before_last", wb_q[2], 1);
            chk("fill4_busy_fall", wb_q[3], 0);
        end

        // Fill of 8 with host words stealing slots 2 and 3.
        clear_log();
        start_fill(16'h0100, 8, 12'h123);
        tick();
        host_wr = 1; host_addr = 14'h3000; host_data = 12'h777; tick();
        host_addr = 14'h3001; tick(); host_wr = 0;
        idle(10);
        exp_a = '{32'h0100, 32'h3000, 32'h3001, 32'h0101, 32'h0102,
                  32'h0103, 32'h0104, 32'h0105, 32'h0106, 32'h0107};
        chk("interleave_count", wa_q.size(), 10);
        for (int i = 0; i < 10 && i < wa_q.size(); i++) chk("interleave_addr", wa_q[i], exp_a[i]);

        // Swap requested during a 100-word fill; display confirms 5 cycles after toggle.
        clear_log();
        start_fill(16'h0400, 100, 12'h0F0);
        idle(2);
        swap_req = 1; tick(); swap_req = 0;
        chk("swap_busy_rise", 32'(swap_busy), 1);
        last_busy = -1; tog = -1;
        for (int i = 0; i < 130; i++) begin
            tick();
            if (fill_busy === 1'b1) last_busy = cyc;
            if (tog < 0 && buf_select === 1'b1) tog = cyc;
            if (tog >= 0 && cyc == tog + 5) buf_current = 1;
        end
        chk("swap_fill_words", wa_q.size(), 100);
        chk("swap_toggle_after_fill", tog - last_busy, 2);
        chk("swap_done_once", done_cnt, 1);
        chk("swap_busy_clear", 32'(swap_busy), 0);

        // Timeout: display stuck at buffer 1 while select moves to 0.
        clear_log();
        swap_req = 1; tick(); swap_req = 0;
        idle(TO + 6);
        chk("timeout_err", 32'(swap_err), 1);
        chk("timeout_busy", 32'(swap_busy), 0);
        chk("timeout_no_done", done_cnt, 0);
        chk("timeout_sel", 32'(buf_select), 0);
        swap_req = 1; tick(); swap_req = 0;
        chk("err_cleared", 32'(swap_err), 0);
        idle(4);
        chk("resync_done", done_cnt, 1);

        // Fill across the top address.
        clear_log();
        start_fill(16'h3FFE, 4, 12'h00C);
        idle(7);
`ifdef MTRX_SCHED_WRAP_EN
        exp_a = '{32'h3FFE, 32'h3FFF, 32'h0000, 32'h0001};
`else
        exp_a = '{32'h3FFE, 32'h3FFF};
`endif
        chk("top_count", wa_q.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) chk("top_addr", wa_q[i], exp_a[i]);
        chk("top_idle", 32'(fill_busy), 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            host_wr     = ($urandom_range(0, 3) == 0);
            host_addr   = AW'($urandom);
            host_data   = DW'($urandom);
            fill_start  = ($urandom_range(0, 7) == 0);
            fill_base   = ($urandom_range(0, 3) == 0) ? AW'(TOP - $urandom_range(0, 6)) : AW'($urandom);
            fill_len    = (AW+1)'($urandom_range(0, 12));
            fill_data   = DW'($urandom);
            swap_req    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 5) == 0) buf_current = m_sel;
            tick();
        end
        rst_n = 1; host_wr = 0; fill_start = 0; swap_req = 0;
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
